// File: rtl/fifo_if.sv
// Signal bundle for a synchronous_fifo instance; lets a bench carry the
// whole FIFO interface through one handle.
interface fifo_if #(
  parameter int DATA_WIDTH = 8
) (
  input logic clk
);
  logic                  rst_n;
  logic                  w_en;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;

  modport dut (
    input  clk, rst_n, w_en, r_en, data_in,
    output data_out, full, empty
  );

  modport tb (
    input  clk, data_out, full, empty,
    output rst_n, w_en, r_en, data_in
  );
endinterface

// File: rtl/synchronous_fifo.sv
// Single-clock FIFO with a registered read port and pointer-based flags.
// Pointers carry one extra wrap bit so full and empty can be told apart
// when the address bits coincide.
module synchronous_fifo #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  // rst_n keeps its historical name but is an active-high reset.
  logic                  rst;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_accept;
  logic                  rd_accept;

  assign rst = rst_n;

  // Flags come straight from the registered pointers.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                 (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

  // Each request is judged on its own against the pre-edge flags.
  assign wr_accept = w_en && !full;
  assign rd_accept = r_en && !empty;

  // Storage array: no reset, stale words are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_accept && !rst) begin
      mem[wr_ptr[ADDR_W-1:0]] <= data_in;
    end
  end

  // Pointer advance and registered read data; reset wins over requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      data_out <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_accept) begin
        data_out <= mem[rd_ptr[ADDR_W-1:0]];
        rd_ptr   <= rd_ptr + PTR_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_synchronous_fifo.sv
// Scoreboard bench for synchronous_fifo: a reference queue predicts read
// data and flag state for every cycle driven.
module tb_synchronous_fifo;
  localparam int DEPTH      = 8;
  localparam int DATA_WIDTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  fifo_if #(.DATA_WIDTH(DATA_WIDTH)) bus (.clk(clk));

  synchronous_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) dut (
    .clk      (bus.clk),
    .rst_n    (bus.rst_n),
    .w_en     (bus.w_en),
    .r_en     (bus.r_en),
    .data_in  (bus.data_in),
    .data_out (bus.data_out),
    .full     (bus.full),
    .empty    (bus.empty)
  );

  logic [DATA_WIDTH-1:0] sb_q [$];
  logic [DATA_WIDTH-1:0] last_out;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // One clock with the given requests; model updates and checks after the edge.
  task automatic step(input logic w, input logic r, input logic [DATA_WIDTH-1:0] d);
    logic                  m_full, m_empty, wacc, racc;
    logic [DATA_WIDTH-1:0] exp_out;
    m_full  = (sb_q.size() == DEPTH);
    m_empty = (sb_q.size() == 0);
    wacc    = w && !m_full;
    racc    = r && !m_empty;
    exp_out = last_out;
    bus.w_en    = w;
    bus.r_en    = r;
    bus.data_in = d;
    if (racc) exp_out = sb_q.pop_front();
    if (wacc) sb_q.push_back(d);
    @(posedge clk);
    #1;
    if (racc) check("rd_data", bus.data_out, exp_out);
    else      check("hold_data", bus.data_out, exp_out);
    last_out = exp_out;
    check("full", bus.full, (sb_q.size() == DEPTH));
    check("empty", bus.empty, (sb_q.size() == 0));
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
  endtask

  // One-cycle reset with arbitrary requests present to prove reset wins.
  task automatic do_reset();
    bus.rst_n   = 1'b1;
    bus.w_en    = 1'b1;
    bus.r_en    = 1'b1;
    bus.data_in = 8'h5C;
    @(posedge clk);
    #1;
    bus.rst_n = 1'b0;
    bus.w_en  = 1'b0;
    bus.r_en  = 1'b0;
    sb_q.delete();
    last_out = '0;
    check("rst_data", bus.data_out, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
  endtask

  initial begin
    bus.rst_n   = 1'b1;
    bus.w_en    = 1'b0;
    bus.r_en    = 1'b0;
    bus.data_in = '0;
    last_out    = '0;

    // Reset state, then random mixed traffic.
    do_reset();
    for (int i = 0; i < 10; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));

    // Fill 0x01..0x08 then drain in order.
    do_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 8'(i));
    check("full_after_8", bus.full, 1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00);
    check("empty_after_drain", bus.empty, 1);

    // Overflow write of 0xFF must be dropped.
    do_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
    step(1'b1, 1'b0, 8'hFF);
    check("full_after_ovf", bus.full, 1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00);
    check("last_not_ff", bus.data_out, 8'h18);

    // Simultaneous read/write while full: read happens, write dropped.
    do_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
    step(1'b1, 1'b1, 8'hAA);
    check("oldest_read", bus.data_out, 8'h21);
    check("not_full_after_rw", bus.full, 0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'h00);
    check("aa_dropped", bus.data_out, 8'h28);

    // Empty read holds data, then wrap-around with 20 write/read pairs.
    step(1'b0, 1'b1, 8'h00);
    check("empty_read_hold", bus.data_out, 8'h28);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 8'(8'h40 + i));
      step(1'b0, 1'b1, 8'h00);
    end
    // Concurrent read/write at partial occupancy keeps occupancy steady.
    step(1'b1, 1'b0, 8'h71);
    step(1'b1, 1'b0, 8'h72);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 8'(8'h80 + i));

    // Mid-operation reset discards three stored entries.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
    do_reset();
    step(1'b0, 1'b1, 8'h00);
    check("no_stale_read", bus.data_out, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
